ex_muldiv: RTL and testbench

//  Multi-cycle multiply/divide unit in the EX stage, downstream of the ALUSrc operand mux.

---
 rtl/ex_muldiv.sv | 154 +++++++++++++++
 tb/tb_ex_muldiv.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 multiply/divide unit for the EX stage.
// Runs MULT/MULTU/DIV/DIVU into HI/LO and handles MTHI/MTLO writes.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op           launch request (IDLE only); op = {is_div, is_signed}
//   operando_a          multiplicand / dividend; also the MTHI/MTLO source
//   operando_b          multiplier / divisor
//   mthi, mtlo          write operando_a into HI / LO (IDLE only)
//   flush               abort the in-flight operation
//   busy                unit is not idle (drives the pipeline stall)
//   done, div_cero      one-cycle result pulse; div_cero flags a zero divisor
//   hi, lo              HI/LO architectural registers
module ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operando_a,
  input  logic [WIDTH-1:0] operando_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_cero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StDzero} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               is_div_q;
  logic               neg_lo_q;  // negate product / quotient
  logic               neg_hi_q;  // negate product / remainder
  logic [WIDTH-1:0]   opb_q;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q, dz_q;

  // Operand magnitudes for the signed ops.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (op[0] && operando_a[WIDTH-1]) ? -operando_a : operando_a;
  assign b_mag = (op[0] && operando_b[WIDTH-1]) ? -operando_b : operando_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    // Shift-add: add multiplicand on a set LSB, then shift right with carry.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Restoring divide: shift next dividend bit into the remainder and trial-subtract.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, opb_q};
    if (is_div_q) begin
      step = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod = neg_lo_q ? -step : step;
    if (is_div_q) begin
      res_lo = neg_lo_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
      res_hi = neg_hi_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mthi) hi_q <= operando_a;
          if (mtlo) lo_q <= operando_a;
          if (start && !flush) begin
            busy_q <= 1'b1;
            if (op[1] && (operando_b == '0)) begin
              state_q <= StDzero;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
            end else begin
              state_q  <= StRun;
              cnt_q    <= CntW'(WIDTH - 1);
              is_div_q <= op[1];
              neg_lo_q <= op[0] & (operando_a[WIDTH-1] ^ operando_b[WIDTH-1]);
              // Remainder follows the dividend; product follows the sign product.
              neg_hi_q <= op[1] ? (op[0] & operando_a[WIDTH-1])
                                : (op[0] & (operando_a[WIDTH-1] ^ operando_b[WIDTH-1]));
              acc_q    <= {{WIDTH{1'b0}}, a_mag};
              opb_q    <= b_mag;
            end
          end
        end
        StRun: begin
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= step;
            if (cnt_q == '0) begin
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        StDone, StDzero: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_cero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_ex_muldiv;

  logic        clk, rst_n, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] operando_a, operando_b;
  logic        busy, done, div_cero;
  logic [31:0] hi, lo;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operando_a(operando_a), .operando_b(operando_b),
    .mthi(mthi), .mtlo(mtlo), .flush(flush),
    .busy(busy), .done(done), .div_cero(div_cero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi, m_lo;
  bit          exp_dz;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference HI/LO semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    exp_dz = 1'b0;
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b01: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b10: if (b == 0) exp_dz = 1'b1; else begin m_lo = a / b; m_hi = a % b; end
      default: if (b == 0) exp_dz = 1'b1;
               else begin
                 q = sa / sb; r = sa % sb;
                 p = q; m_lo = p[31:0];
                 p = r; m_hi = p[31:0];
               end
    endcase
  endfunction

  // Call at a negedge; returns 1 time unit after launch edge 0 with operands scrambled.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit wr);
    start = 1'b1; op = o; operando_a = a; operando_b = b; mthi = wr; mtlo = wr;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    operando_a = $urandom; operando_b = $urandom;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit wr, input string tag);
    int exp_cyc;
    bit seen;
    model(o, a, b);
    if (exp_dz && wr) begin m_hi = a; m_lo = a; end
    exp_cyc = exp_dz ? 1 : 33;
    launch(o, a, b, wr);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (wr && cyc == 1 && !exp_dz) chk({tag, "_mt_write"}, {hi, lo}, {a, a});
      if (done) begin
        seen = 1'b1;
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        chk({tag, "_div_cero"}, div_cero, exp_dz);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
      end else begin
        chk({tag, "_busy"}, busy, 1);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    else begin
      @(negedge clk);
      chk({tag, "_idle_after"}, {busy, done}, 0);
    end
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; operando_a = h;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b1; operando_a = l;
    @(posedge clk); #1;
    mtlo = 1'b0;
    m_hi = h; m_lo = l;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 20);
    return $urandom;
  endfunction

  int          dcnt;
  bit          ok;
  logic [31:0] ra, rb;

  initial begin
    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'b00; operando_a = '0; operando_b = '0;
    m_hi = '0; m_lo = '0;
    #12;
    chk("reset_outputs", {busy, done, div_cero, hi, lo}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, "mult_neg3x7");
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, "mult_minsq");
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, "div_neg7by2");
    do_op(2'b10, 32'd100, 32'd7, 0, "divu_100by7");
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");
    write_hilo(32'h11, 32'h22);
    chk("mthi_mtlo", {hi, lo}, {32'h11, 32'h22});
    do_op(2'b11, 32'd5, 32'd0, 0, "div_by_zero");
    do_op(2'b01, 32'hFFFF_FF00, 32'd3, 1, "mt_with_start");

    for (int i = 0; i < 40; i++) begin
      ra = pick(); rb = pick();
      do_op(2'($urandom_range(0, 3)), ra, rb, 0, "rand");
    end

    // start held high: second launch sampled only in cycle 34.
    write_hilo(32'hA5A5_A5A5, 32'h5A5A_5A5A);
    model(2'b10, 32'd1000, 32'd9);
    start = 1'b1; op = 2'b10; operando_a = 32'd1000; operando_b = 32'd9;
    @(posedge clk); #1;
    dcnt = 0;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (cyc == 33) chk("hold_done_at_33", done, 1);
      if (cyc == 34) chk("hold_idle_at_34", busy, 0);
    end
    chk("hold_one_done", dcnt, 1);
    @(negedge clk);
    chk("hold_relaunch_35", busy, 1);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("hold_flush_idle", busy, 0);
    chk("hold_result", {hi, lo}, {m_hi, m_lo});

    // Flush at cycle 10; busy mthi/mtlo must be ignored as well.
    write_hilo(32'h1234_5678, 32'h9ABC_DEF0);
    launch(2'b00, 32'd77, 32'd88, 0);
    ok = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (done) ok = 1'b0;
      if (cyc == 5) begin mthi = 1'b1; mtlo = 1'b1; operando_a = 32'hBAD0_BAD0; end
      if (cyc == 6) begin mthi = 1'b0; mtlo = 1'b0; end
      if (cyc == 10) begin chk("flush_busy_c10", busy, 1); flush = 1'b1; end
      if (cyc == 11) begin flush = 1'b0; chk("flush_busy_c11", busy, 0); end
    end
    chk("flush_no_done", ok, 1);
    chk("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});

    // flush and start together: nothing launches.
    start = 1'b1; flush = 1'b1; op = 2'b01; operando_a = 32'd3; operando_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_beats_start", {busy, done}, 0);

    // Asynchronous reset in the middle of RUN.
    launch(2'b01, 32'hDEAD_0001, 32'h0000_BEEF, 0);
    for (int cyc = 1; cyc < 15; cyc++) @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, done, hi, lo}, 0);
    @(negedge clk); rst_n = 1'b1;
    mtlo = 1'b1; operando_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mtlo = 1'b0;
    @(negedge clk);
    chk("mtlo_after_reset", {hi, lo}, {32'h0, 32'hDEAD_BEEF});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
